uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_rx_sync.sv | 32 +++
 rtl/uart_rx.sv | 184 ++++++++++++++++++
 tb/tb_uart_rx.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding and default
// frame geometry. The parity state and helper exist only when
// UART_RX_PARITY_EN is defined.
package uart_pkg;

  localparam int OVERSAMPLE_DEF = 16;
  localparam int DATA_BITS_DEF  = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } uart_state_e;

`ifdef UART_RX_PARITY_EN
  // Even parity: 1 when the payload holds an odd number of ones.
  function automatic logic even_parity(input logic [63:0] d);
    return ^d;
  endfunction
`endif

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous rx line plus a falling-edge
// detector on the synchronized value. All flops reset to the idle level (1)
// so that reset release never looks like a start edge.
module uart_rx_sync (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_rx,
  output logic o_rx_s,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  // Metastability chain followed by one history flop for edge detection.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
      r_prev <= 1'b1;
    end else begin
      r_meta <= i_rx;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_rx_s = r_sync;
  assign o_fall = r_prev & ~r_sync;

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver with a one-entry output holding register.
// Frame: start + DATA_BITS (LSB first) + [even parity] + stop.
// Optional feature macro: UART_RX_PARITY_EN (adds the parity bit check).
module uart_rx
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int DATA_BITS  = DATA_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  input  logic                 tick,
  input  logic                 rx_ack,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 overrun_err,
  output logic                 rx_busy
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] C_HALF  = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] C_LAST  = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] C_BLAST = BW'(DATA_BITS - 1);

  uart_state_e          r_state, w_state_nxt;
  logic [CW-1:0]        r_cnt, w_cnt_nxt;
  logic [BW-1:0]        r_bit, w_bit_nxt;
  logic [DATA_BITS-1:0] r_shift, w_shift_nxt;
  logic                 w_commit;
  logic                 w_ferr;
  logic                 w_rx_s;
  logic                 w_fall;
`ifdef UART_RX_PARITY_EN
  logic                 r_par, w_par_nxt;
  logic                 w_par_ok;
`endif

  uart_rx_sync u_sync (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_rx    (rx),
    .o_rx_s  (w_rx_s),
    .o_fall  (w_fall)
  );

`ifdef UART_RX_PARITY_EN
  assign w_par_ok = (even_parity(64'(r_shift)) == r_par);
`endif

  // Next-state, counter and shift-register update; only IDLE reacts without tick.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_commit    = 1'b0;
    w_ferr      = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_par_nxt   = r_par;
`endif
    case (r_state)
      ST_IDLE: begin
        if (w_fall) begin
          w_state_nxt = ST_START;
          w_cnt_nxt   = '0;
        end
      end
      ST_START: begin
        if (tick) begin
          if (r_cnt == C_HALF) begin
            w_cnt_nxt   = '0;
            w_bit_nxt   = '0;
            // A line back high at mid-start is a glitch: drop silently.
            w_state_nxt = w_rx_s ? ST_IDLE : ST_DATA;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (r_cnt == C_LAST) begin
            w_cnt_nxt                   = '0;
            w_shift_nxt                 = r_shift >> 1;
            w_shift_nxt[DATA_BITS-1]    = w_rx_s;
            w_bit_nxt                   = r_bit + 1'b1;
            if (r_bit == C_BLAST) begin
`ifdef UART_RX_PARITY_EN
              w_state_nxt = ST_PARITY;
`else
              w_state_nxt = ST_STOP;
`endif
            end
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (tick) begin
          if (r_cnt == C_LAST) begin
            w_cnt_nxt   = '0;
            w_par_nxt   = w_rx_s;
            w_state_nxt = ST_STOP;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
`endif
      ST_STOP: begin
        if (tick) begin
          if (r_cnt == C_LAST) begin
            w_cnt_nxt   = '0;
            w_state_nxt = ST_IDLE;
`ifdef UART_RX_PARITY_EN
            w_commit    = w_rx_s & w_par_ok;
            w_ferr      = ~(w_rx_s & w_par_ok);
`else
            w_commit    = w_rx_s;
            w_ferr      = ~w_rx_s;
`endif
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // FSM state and bit/tick counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
`ifdef UART_RX_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bit   <= w_bit_nxt;
`ifdef UART_RX_PARITY_EN
      r_par   <= w_par_nxt;
`endif
    end
  end

  // Payload shift register; contents are don't-care until a frame completes.
  always_ff @(posedge clk) begin
    r_shift <= w_shift_nxt;
  end

  // Output holding register: commit, consume, overrun and error pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      frame_err   <= w_ferr;
      overrun_err <= w_commit & rx_valid & ~rx_ack;
      if (w_commit && (!rx_valid || rx_ack)) begin
        rx_data  <= r_shift;
        rx_valid <= 1'b1;
      end else if (rx_ack) begin
        rx_valid <= 1'b0;
      end
    end
  end

  assign rx_busy = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: tick every 4 clk, OVERSAMPLE=16, 8-bit frames.
// Honors UART_RX_PARITY_EN to match the build of the receiver.
module tb_uart_rx;

  localparam int OS     = 16;
  localparam int DB     = 8;
  localparam int BITCLK = OS * 4;
`ifdef UART_RX_PARITY_EN
  localparam int FRAME_TICKS = OS / 2 + DB * OS + OS + OS;
`else
  localparam int FRAME_TICKS = OS / 2 + DB * OS + OS;
`endif

  logic          clk    = 1'b0;
  logic          rst    = 1'b0;
  logic          rx     = 1'b1;
  logic          tick   = 1'b0;
  logic          rx_ack = 1'b0;
  logic [DB-1:0] rx_data;
  logic          rx_valid;
  logic          frame_err;
  logic          overrun_err;
  logic          rx_busy;

  int   total = 0;
  int   bad   = 0;
  int   n_vrise = 0, n_vfall = 0, n_ferr = 0, n_ovr = 0;
  logic prev_v  = 1'b0;
  logic arm_ack = 1'b0;
  logic ack_req = 1'b0;
  int   tk      = 0;
  int   phase   = 0;

  typedef struct {
    logic [7:0] d;
    logic       stop;
    logic [7:0] exp_d;
    logic       exp_v;
    int         exp_ferr;
  } vec_t;

  vec_t tbl[5];

  always #5 clk = ~clk;

  uart_rx #(.OVERSAMPLE(OS), .DATA_BITS(DB)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx          (rx),
    .tick        (tick),
    .rx_ack      (rx_ack),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .frame_err   (frame_err),
    .overrun_err (overrun_err),
    .rx_busy     (rx_busy)
  );

  // Tick generator (every 4th clk) and rx_ack driver. When armed, rx_ack is
  // raised exactly on the frame's stop-sample tick, counted from START entry.
  initial forever begin
    @(negedge clk);
    phase = (phase + 1) % 4;
    tick  = (phase == 0);
    if (rx_busy) begin
      if (tick) tk++;
    end else begin
      tk = 0;
    end
    rx_ack = ack_req | (arm_ack & tick & (tk == FRAME_TICKS));
  end

  // Output monitor.
  initial forever begin
    @(negedge clk);
    if (rx_valid && !prev_v) n_vrise++;
    if (!rx_valid && prev_v) n_vfall++;
    if (frame_err)   n_ferr++;
    if (overrun_err) n_ovr++;
    prev_v = rx_valid;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic clr_counts();
    @(negedge clk);
    #1;
    n_vrise = 0; n_vfall = 0; n_ferr = 0; n_ovr = 0;
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk);
    rx = b;
    repeat (BITCLK - 1) @(negedge clk);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    rx = 1'b1;
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < DB; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(^d);
`endif
    send_bit(stop);
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic send_frame_par(input logic [7:0] d, input logic par, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < DB; i++) send_bit(d[i]);
    send_bit(par);
    send_bit(stop);
  endtask
`endif

  task automatic ack_once();
    @(negedge clk);
    #1 ack_req = 1'b1;
    @(negedge clk);
    #1 ack_req = 1'b0;
    @(negedge clk);
    #1;
  endtask

  initial begin
    tbl[0] = '{d: 8'hA5, stop: 1'b1, exp_d: 8'hA5, exp_v: 1'b1, exp_ferr: 0};
    tbl[1] = '{d: 8'h3C, stop: 1'b0, exp_d: 8'hA5, exp_v: 1'b0, exp_ferr: 1};
    tbl[2] = '{d: 8'h00, stop: 1'b1, exp_d: 8'h00, exp_v: 1'b1, exp_ferr: 0};
    tbl[3] = '{d: 8'hFF, stop: 1'b1, exp_d: 8'hFF, exp_v: 1'b1, exp_ferr: 0};
    tbl[4] = '{d: 8'h81, stop: 1'b1, exp_d: 8'h81, exp_v: 1'b1, exp_ferr: 0};

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_rx_data", 32'(rx_data), 32'h00);
    chk("rst_rx_valid", 32'(rx_valid), 32'h0);
    chk("rst_frame_err", 32'(frame_err), 32'h0);
    chk("rst_overrun_err", 32'(overrun_err), 32'h0);
    chk("rst_rx_busy", 32'(rx_busy), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    idle(BITCLK);

    // Table-driven single frames
    for (int v = 0; v < 5; v++) begin
      clr_counts();
      send_frame(tbl[v].d, tbl[v].stop);
      idle(BITCLK);
      chk($sformatf("vec%0d_rx_data", v), 32'(rx_data), 32'(tbl[v].exp_d));
      chk($sformatf("vec%0d_rx_valid", v), 32'(rx_valid), 32'(tbl[v].exp_v));
      chk($sformatf("vec%0d_valid_rises", v), 32'(n_vrise), 32'(tbl[v].exp_v));
      chk($sformatf("vec%0d_frame_err_cycles", v), 32'(n_ferr), 32'(tbl[v].exp_ferr));
      chk($sformatf("vec%0d_overrun", v), 32'(n_ovr), 32'h0);
      chk($sformatf("vec%0d_busy", v), 32'(rx_busy), 32'h0);
      if (tbl[v].exp_v) begin
        ack_once();
        chk($sformatf("vec%0d_valid_after_ack", v), 32'(rx_valid), 32'h0);
        chk($sformatf("vec%0d_data_after_ack", v), 32'(rx_data), 32'(tbl[v].exp_d));
      end
    end

    // Start glitch: low for 3 ticks only
    clr_counts();
    @(negedge clk);
    rx = 1'b0;
    repeat (12) @(negedge clk);
    idle(2 * BITCLK);
    chk("glitch_valid_rises", 32'(n_vrise), 32'h0);
    chk("glitch_frame_err", 32'(n_ferr), 32'h0);
    chk("glitch_overrun", 32'(n_ovr), 32'h0);
    chk("glitch_busy", 32'(rx_busy), 32'h0);

    // Back-to-back without ack: second byte dropped
    clr_counts();
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    idle(BITCLK);
    chk("ovr_rx_data", 32'(rx_data), 32'h11);
    chk("ovr_rx_valid", 32'(rx_valid), 32'h1);
    chk("ovr_overrun_cycles", 32'(n_ovr), 32'h1);
    chk("ovr_valid_rises", 32'(n_vrise), 32'h1);
    ack_once();
    chk("ovr_valid_after_ack", 32'(rx_valid), 32'h0);

    // Back-to-back with ack on the commit cycle: second byte replaces first
    clr_counts();
    send_frame(8'h11, 1'b1);
    arm_ack = 1'b1;
    send_frame(8'h22, 1'b1);
    idle(BITCLK);
    arm_ack = 1'b0;
    chk("ackc_rx_data", 32'(rx_data), 32'h22);
    chk("ackc_rx_valid", 32'(rx_valid), 32'h1);
    chk("ackc_overrun", 32'(n_ovr), 32'h0);
    chk("ackc_valid_falls", 32'(n_vfall), 32'h0);
    ack_once();

    // Reset in the middle of a 0xFF frame, then 0x5A
    clr_counts();
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    @(negedge clk);
    rst = 1'b0;
    rx  = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    chk("midrst_busy", 32'(rx_busy), 32'h0);
    chk("midrst_data", 32'(rx_data), 32'h00);
    @(negedge clk);
    rst = 1'b1;
    idle(2 * BITCLK);
    chk("midrst_no_output", 32'(n_vrise + n_ferr + n_ovr), 32'h0);
    send_frame(8'h5A, 1'b1);
    idle(BITCLK);
    chk("midrst_rx_data", 32'(rx_data), 32'h5A);
    chk("midrst_valid_rises", 32'(n_vrise), 32'h1);
    chk("midrst_frame_err", 32'(n_ferr), 32'h0);
    ack_once();

`ifdef UART_RX_PARITY_EN
    // Even parity: 0x07 has three ones, so the parity bit must be 1
    clr_counts();
    send_frame_par(8'h07, 1'b1, 1'b1);
    idle(BITCLK);
    chk("par_ok_rx_data", 32'(rx_data), 32'h07);
    chk("par_ok_valid", 32'(rx_valid), 32'h1);
    chk("par_ok_frame_err", 32'(n_ferr), 32'h0);
    ack_once();
    clr_counts();
    send_frame_par(8'h07, 1'b0, 1'b1);
    idle(BITCLK);
    chk("par_bad_frame_err", 32'(n_ferr), 32'h1);
    chk("par_bad_valid_rises", 32'(n_vrise), 32'h0);
    chk("par_bad_valid", 32'(rx_valid), 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
